// File: rtl/updown_pkg.sv
// Shared types and constants for the up/down button pulse generator.
package updown_pkg;

    // Per-button command state: waiting, first pulse, held, auto-repeating
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS  = 2'd1,
        HOLD   = 2'd2,
        REPEAT = 2'd3
    } btn_state_t;

    // Depth of the metastability synchroniser on each raw button input
    localparam int SYNC_STAGES = 2;

    // Larger of two integers, used to size the shared repeat timer
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/updown_pulse_gen_button_channel.sv
// One button path: synchroniser, debouncer, command FSM and repeat timer.
// The pulse output is combinational here and is registered by the top level,
// so a state transition and its output register update share the same edge.
module button_channel
    import updown_pkg::*;
#(
    parameter int DebounceCycles    = 1_000_000,
    parameter bit RepeatOn          = 1'b0,
    parameter int RepeatDelayCycles = 25_000_000,
    parameter int RepeatRateCycles  = 10_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    input  logic inhibit,
    output logic level,
    output logic pulse
);

    localparam int DB_W  = $clog2(DebounceCycles);
    localparam int TMR_W = $clog2(max_int(RepeatDelayCycles, RepeatRateCycles));

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DebounceCycles - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(RepeatDelayCycles - 1);
    localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(RepeatRateCycles - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [DB_W-1:0]        db_cnt;
    logic                   level_q;
    btn_state_t             state, state_nx;
    logic [TMR_W-1:0]       timer, timer_nx;
    logic                   fire;

    assign synced = sync_q[SYNC_STAGES-1];
    assign level  = level_q;
    assign pulse  = fire;

    // Shift the raw button through the synchroniser chain
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
        end
    end

    // Accept a new level only after it has disagreed for DebounceCycles clocks
    always_ff @(posedge clock) begin
        if (reset) begin
            db_cnt  <= '0;
            level_q <= 1'b0;
        end else if (synced == level_q) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            level_q <= synced;
            db_cnt  <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Next-state logic: release wins, then the interlock, then normal sequencing
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        fire     = 1'b0;
        if (!level_q) begin
            state_nx = IDLE;
            timer_nx = '0;
        end else if (inhibit) begin
            state_nx = HOLD;
            timer_nx = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = PRESS;
                    timer_nx = '0;
                    fire     = 1'b1;
                end
                PRESS: begin
                    state_nx = HOLD;
                    if (RepeatOn) begin
                        timer_nx = timer + 1'b1;
                    end
                end
                HOLD: begin
                    if (RepeatOn) begin
                        if (timer == DELAY_LAST) begin
                            state_nx = REPEAT;
                            timer_nx = '0;
                            fire     = 1'b1;
                        end else begin
                            timer_nx = timer + 1'b1;
                        end
                    end
                end
                REPEAT: begin
                    if (timer == RATE_LAST) begin
                        timer_nx = '0;
                        fire     = 1'b1;
                    end else begin
                        timer_nx = timer + 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    timer_nx = '0;
                end
            endcase
        end
    end

    // Register the command FSM and its repeat timer
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
        end
    end

endmodule

// File: rtl/updown_pulse_gen.sv
// Turns two raw push-buttons into clean one-clock Up/Down counter commands.
// Holds the interlock between the two channels and the output registers.
module updown_pulse_gen
    import updown_pkg::*;
#(
    parameter int    DebounceCycles    = 1_000_000,
    parameter string RepeatEnable      = "No",
    parameter int    RepeatDelayCycles = 25_000_000,
    parameter int    RepeatRateCycles  = 10_000_000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic BtnUp,
    input  logic BtnDown,
    output logic Up,
    output logic Down,
    output logic Busy
);

    localparam bit REPEAT_ON = (RepeatEnable == "Yes");

    logic level_up, level_down;
    logic pulse_up, pulse_down;
    logic both_held;

    assign both_held = level_up & level_down;

    button_channel #(
        .DebounceCycles   (DebounceCycles),
        .RepeatOn         (REPEAT_ON),
        .RepeatDelayCycles(RepeatDelayCycles),
        .RepeatRateCycles (RepeatRateCycles)
    ) up_channel (
        .clock  (Clock),
        .reset  (Reset),
        .btn    (BtnUp),
        .inhibit(both_held),
        .level  (level_up),
        .pulse  (pulse_up)
    );

    button_channel #(
        .DebounceCycles   (DebounceCycles),
        .RepeatOn         (REPEAT_ON),
        .RepeatDelayCycles(RepeatDelayCycles),
        .RepeatRateCycles (RepeatRateCycles)
    ) down_channel (
        .clock  (Clock),
        .reset  (Reset),
        .btn    (BtnDown),
        .inhibit(both_held),
        .level  (level_down),
        .pulse  (pulse_down)
    );

    // Register commands with the interlock applied, and Busy alongside them
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Up   <= 1'b0;
            Down <= 1'b0;
            Busy <= 1'b0;
        end else begin
            Up   <= pulse_up & ~both_held;
            Down <= pulse_down & ~both_held;
            Busy <= level_up | level_down;
        end
    end

endmodule

// File: tb/tb_updown_pulse_gen.sv
// Self-checking bench for updown_pulse_gen: one instance without auto-repeat,
// one with. Expected pulse edges are queued when buttons are driven and
// matched against the pulses the DUTs actually produce.
module tb_updown_pulse_gen;

    localparam int DB   = 4;
    localparam int DLY  = 10;
    localparam int RATE = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic up_n = 1'b0, dn_n = 1'b0, up_y = 1'b0, dn_y = 1'b0;
    logic out_up_n, out_dn_n, busy_n;
    logic out_up_y, out_dn_y, busy_y;

    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    bit   mon_en     = 1'b0;
    int   exp_v;
    int   exp_q [4][$];
    logic obs [4];
    logic prev_pulse [4];

    updown_pulse_gen #(
        .DebounceCycles   (DB),
        .RepeatEnable     ("No"),
        .RepeatDelayCycles(DLY),
        .RepeatRateCycles (RATE)
    ) dut_n (
        .Clock  (clk),
        .Reset  (rst),
        .BtnUp  (up_n),
        .BtnDown(dn_n),
        .Up     (out_up_n),
        .Down   (out_dn_n),
        .Busy   (busy_n)
    );

    updown_pulse_gen #(
        .DebounceCycles   (DB),
        .RepeatEnable     ("Yes"),
        .RepeatDelayCycles(DLY),
        .RepeatRateCycles (RATE)
    ) dut_y (
        .Clock  (clk),
        .Reset  (rst),
        .BtnUp  (up_y),
        .BtnDown(dn_y),
        .Up     (out_up_y),
        .Down   (out_dn_y),
        .Busy   (busy_y)
    );

    // 20 ns system clock
    always #10 clk = ~clk;

    // Edge counter: after rising edge n, cyc == n
    always @(posedge clk) cyc <= cyc + 1;

    // Direct comparison of one output against a value the bench worked out
    task automatic check_output(input string tag, input logic observed, input logic expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%b expected=%b at cycle %0d", tag, observed, expected, cyc);
        end
    endtask

    // Drive one button: 0 up_n, 1 dn_n, 2 up_y, 3 dn_y
    task automatic apply_stimulus(input int ch, input logic val);
        case (ch)
            0: up_n = val;
            1: dn_n = val;
            2: up_y = val;
            3: dn_y = val;
            default: ;
        endcase
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Per-cycle monitor: interlock, pulse width and scoreboard matching
    always @(negedge clk) begin
        if (mon_en) begin
            obs[0] = out_up_n;
            obs[1] = out_dn_n;
            obs[2] = out_up_y;
            obs[3] = out_dn_y;
            compared += 2;
            assert ((out_up_n & out_dn_n) === 1'b0)
            else begin
                mismatched++;
                $error("[TB] FAIL interlock_n observed=%b%b expected=not both at cycle %0d", out_up_n, out_dn_n, cyc);
            end
            assert ((out_up_y & out_dn_y) === 1'b0)
            else begin
                mismatched++;
                $error("[TB] FAIL interlock_y observed=%b%b expected=not both at cycle %0d", out_up_y, out_dn_y, cyc);
            end
            for (int ch = 0; ch < 4; ch++) begin
                if (prev_pulse[ch] === 1'b1) begin
                    compared++;
                    assert (obs[ch] === 1'b0)
                    else begin
                        mismatched++;
                        $error("[TB] FAIL pulse_width ch%0d observed=%b expected=0 at cycle %0d", ch, obs[ch], cyc);
                    end
                end
                if (obs[ch] === 1'b1) begin
                    if (exp_q[ch].size() > 0) exp_v = exp_q[ch].pop_front();
                    else exp_v = -1;
                    compared++;
                    assert (cyc === exp_v)
                    else begin
                        mismatched++;
                        $error("[TB] FAIL pulse_time ch%0d observed=%0d expected=%0d", ch, cyc, exp_v);
                    end
                end else if (exp_q[ch].size() > 0 && exp_q[ch][0] < cyc) begin
                    exp_v = exp_q[ch].pop_front();
                    compared++;
                    assert (obs[ch] === 1'b1)
                    else begin
                        mismatched++;
                        $error("[TB] FAIL missed_pulse ch%0d observed=none expected=cycle %0d", ch, exp_v);
                    end
                end
                prev_pulse[ch] = obs[ch];
            end
        end
    end

    // Directed sequence of scenarios
    initial begin
        int e0, e0r, f0, fall, t;
        for (int ch = 0; ch < 4; ch++) prev_pulse[ch] = 1'b0;

        $display("[TB] reset with buttons released");
        repeat (3) begin
            @(negedge clk);
            mon_en = 1'b1;
            check_output("rst_up_n", out_up_n, 1'b0);
            check_output("rst_busy_n", busy_n, 1'b0);
            check_output("rst_up_y", out_up_y, 1'b0);
            check_output("rst_busy_y", busy_y, 1'b0);
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_output("post_rst_dn_n", out_dn_n, 1'b0);
            check_output("post_rst_busy_n", busy_n, 1'b0);
            check_output("post_rst_dn_y", out_dn_y, 1'b0);
        end

        $display("[TB] single press without repeat");
        apply_stimulus(0, 1'b1);
        e0 = cyc + 1;
        exp_q[0].push_back(e0 + DB + 2);
        wait_cycles(10);
        check_output("t2_busy_held", busy_n, 1'b1);
        wait_cycles(20);
        apply_stimulus(0, 1'b0);
        wait_cycles(12);
        check_output("t2_busy_released", busy_n, 1'b0);

        $display("[TB] glitches then a clean press on down");
        for (int w = 1; w < DB; w++) begin
            apply_stimulus(1, 1'b1);
            wait_cycles(w);
            apply_stimulus(1, 1'b0);
            wait_cycles(8);
            check_output("t3_glitch_busy", busy_n, 1'b0);
        end
        apply_stimulus(1, 1'b1);
        e0 = cyc + 1;
        exp_q[1].push_back(e0 + DB + 2);
        wait_cycles(DB);
        apply_stimulus(1, 1'b0);
        wait_cycles(3);
        check_output("t3_busy_accepted", busy_n, 1'b1);
        wait_cycles(12);
        check_output("t3_busy_released", busy_n, 1'b0);

        $display("[TB] auto-repeat while held");
        apply_stimulus(2, 1'b1);
        e0 = cyc + 1;
        fall = e0 + 40 + DB + 1;
        exp_q[2].push_back(e0 + DB + 2);
        t = e0 + DB + 2 + DLY;
        while (t <= fall) begin
            exp_q[2].push_back(t);
            t += RATE;
        end
        wait_cycles(40);
        apply_stimulus(2, 1'b0);
        wait_cycles(15);
        check_output("t4_busy_released", busy_y, 1'b0);

        $display("[TB] interlock with both buttons held");
        apply_stimulus(2, 1'b1);
        e0 = cyc + 1;
        exp_q[2].push_back(e0 + DB + 2);
        wait_cycles(10);
        apply_stimulus(3, 1'b1);
        wait_cycles(12);
        check_output("t5_busy_both", busy_y, 1'b1);
        check_output("t5_up_silent", out_up_y, 1'b0);
        wait_cycles(8);
        apply_stimulus(3, 1'b0);
        f0   = e0 + 30 + DB + 1;
        fall = e0 + 52 + DB + 1;
        t = f0 + DLY;
        while (t <= fall) begin
            exp_q[2].push_back(t);
            t += RATE;
        end
        wait_cycles(22);
        apply_stimulus(2, 1'b0);
        wait_cycles(15);

        $display("[TB] reset while a button is held");
        apply_stimulus(2, 1'b1);
        e0 = cyc + 1;
        exp_q[2].push_back(e0 + DB + 2);
        wait_cycles(11);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_output("t6_rst_up", out_up_y, 1'b0);
            check_output("t6_rst_busy", busy_y, 1'b0);
        end
        rst = 1'b0;
        e0r = cyc + 1;
        exp_q[2].push_back(e0r + DB + 2);
        wait_cycles(8);
        apply_stimulus(2, 1'b0);
        wait_cycles(15);

        $display("[TB] simultaneous press");
        apply_stimulus(0, 1'b1);
        apply_stimulus(1, 1'b1);
        wait_cycles(10);
        check_output("t7_busy_both", busy_n, 1'b1);
        apply_stimulus(0, 1'b0);
        apply_stimulus(1, 1'b0);
        wait_cycles(12);
        check_output("t7_busy_released", busy_n, 1'b0);

        for (int ch = 0; ch < 4; ch++) begin
            compared++;
            assert (exp_q[ch].size() === 0)
            else begin
                mismatched++;
                $error("[TB] FAIL pending_pulses ch%0d observed=%0d expected=0", ch, exp_q[ch].size());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
